// File: rtl/exc_sequencer.sv
// exc_sequencer: interrupt entry/exit sequencer between device IRQ lines, CP0 and the fetch unit.
// Build option EXC_SEQ_IRQ_LEVEL_EN: hwint follows registered dev_irq levels instead of sticky edges.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned DRAIN_MAX    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  dev_irq,
  input  logic [5:0]  irq_ack,
  output logic [5:0]  hwint,
  input  logic        int_req,
  input  logic        eret,
  input  logic [29:0] epc,
  input  logic        pipe_busy,
  output logic        stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        exl_clr,
  output logic        in_handler,
  output logic [15:0] int_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRAIN   = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_HANDLER = 3'd3;
  localparam logic [2:0] S_RETURN  = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [7:0]  r_drain_cnt;
  logic [15:0] r_int_count;
  logic [5:0]  r_dev_q;
  logic        w_drain_done;

  // Drain ends when memory goes quiet, or is forced after DRAIN_MAX cycles.
  assign w_drain_done = !pipe_busy || (r_drain_cnt == 8'(DRAIN_MAX - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (int_req) begin
          w_state_nxt = pipe_busy ? S_DRAIN : S_FLUSH;
        end else if (eret) begin
          w_state_nxt = S_RETURN;
        end
      end
      S_DRAIN:   if (w_drain_done) w_state_nxt = S_FLUSH;
      S_FLUSH:   w_state_nxt = S_HANDLER;
      S_HANDLER: if (eret) w_state_nxt = S_RETURN;
      S_RETURN:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Held at zero outside DRAIN, so every DRAIN entry starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= 8'd0;
    end else if (r_state == S_DRAIN) begin
      r_drain_cnt <= r_drain_cnt + 8'd1;
    end else begin
      r_drain_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_count <= 16'd0;
    end else if (r_state == S_FLUSH) begin
      r_int_count <= r_int_count + 16'd1;
    end
  end

`ifdef EXC_SEQ_IRQ_LEVEL_EN
  logic w_unused_ack;
  assign w_unused_ack = ^irq_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dev_q <= 6'd0;
    end else begin
      r_dev_q <= dev_irq;
    end
  end

  assign hwint = r_dev_q;
`else
  logic [5:0] r_hwint;

  // A rising edge outranks a same-cycle ack so no request is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dev_q <= 6'd0;
      r_hwint <= 6'd0;
    end else begin
      r_dev_q <= dev_irq;
      r_hwint <= (r_hwint & ~irq_ack) | (dev_irq & ~r_dev_q);
    end
  end

  assign hwint = r_hwint;
`endif

  // pc_redirect is a one-cycle strobe; pc_target is only meaningful while it is high.
  assign stall       = (r_state == S_DRAIN) || (r_state == S_FLUSH);
  assign flush       = (r_state == S_FLUSH) || (r_state == S_RETURN);
  assign pc_redirect = (r_state == S_FLUSH) || (r_state == S_RETURN);
  assign exl_clr     = (r_state == S_RETURN);
  assign in_handler  = (r_state == S_HANDLER);
  assign int_count   = r_int_count;

  always_comb begin
    pc_target = 32'd0;
    if (r_state == S_FLUSH) begin
      pc_target = HANDLER_ADDR;
    end else if (r_state == S_RETURN) begin
      pc_target = {epc, 2'b00};
    end
  end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception/interrupt sequencer that sits between the device interrupt lines, CP0 and the pipeline front end. It latches device requests into the pending vector feeding CP0 `HWInt`. When CP0 raises its interrupt request, it drains outstanding memory operations, flushes the pipeline and redirects fetch to the handler. On `eret` it clears `EXL` in CP0 and redirects fetch back to the saved EPC.

## Interface
Parameters:
- `HANDLER_ADDR`, 32'h0000_4180, fetch target on interrupt entry.
- `DRAIN_MAX`, 8, maximum cycles spent waiting for `pipe_busy` to fall (1..255).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset; asynchronous, active-high.
- `dev_irq` in 6: raw device interrupt lines, bit i maps to `HWInt[i]`.
- `irq_ack` in 6: per-source clear pulses from the handler's device write.
- `hwint` out 6: pending vector to CP0 `HWInt`.
- `int_req` in 1: CP0 `IntBeq`.
- `eret` in 1: ERET decoded at commit, one-cycle pulse.
- `epc` in 30: CP0 `EPCOut[31:2]`.
- `pipe_busy` in 1: memory access in flight.
- `stall` out 1: freeze fetch/issue.
- `flush` out 1: kill all in-flight instructions.
- `pc_redirect` out 1: load `pc_target` into PC.
- `pc_target` out 32: redirect address.
- `exl_clr` out 1: CP0 `EXLClr`.
- `in_handler` out 1: high from handler entry until return.
- `int_count` out 16: number of interrupts taken.

## Operation
- States: IDLE, DRAIN, FLUSH, HANDLER, RETURN.
- **IDLE**
  - `int_req` high and `pipe_busy` high -> DRAIN.
  - `int_req` high and `pipe_busy` low -> FLUSH.
  - Otherwise `eret` high -> RETURN.
  - `int_req` has priority over `eret`.
- **DRAIN**
  - `stall`=1 throughout.
  - An 8-bit counter is loaded with 0 on entry and increments every cycle.
  - Exit to FLUSH when `pipe_busy`=0, or when the counter reaches `DRAIN_MAX`-1 (forced).
  - `int_req` is not re-sampled here; CP0 has already set EXL.
- **FLUSH**
  - Single cycle with `flush`=1, `pc_redirect`=1, `pc_target`=`HANDLER_ADDR`, `stall`=1.
  - `int_count` increments (wraps FFFF->0000).
  - Next state HANDLER.
- **HANDLER**
  - `in_handler`=1.
  - `eret` -> RETURN.
  - `int_req` is ignored (nested interrupts are not supported).
- **RETURN**
  - Single cycle with `exl_clr`=1, `flush`=1, `pc_redirect`=1, `pc_target`={`epc`,2'b00}.
  - Next state IDLE.
- **Pending vector** (default build):
  - `hwint[i]` sets on a rising edge of `dev_irq[i]`, detected against a registered copy of `dev_irq`.
  - `hwint[i]` clears on `irq_ack[i]`.
  - Set and ack in the same cycle -> set wins.
  - Pending updates continue in every state.
- Outputs not named for a state are 0 in that state. `pc_target` is 0 whenever `pc_redirect`=0.

## Timing
- Reset (async):
  - State IDLE.
  - `hwint`, `int_count`, the drain counter and the `dev_irq` edge register all 0.
  - All outputs 0.
- `int_req` high in IDLE with `pipe_busy`=0 gives `pc_redirect` to `HANDLER_ADDR` exactly 1 cycle later.
- Drain path: `pc_redirect` comes 1 cycle after `pipe_busy` falls, never more than `DRAIN_MAX`+1 cycles after `int_req`.
- `eret` gives `exl_clr`/`pc_redirect` 1 cycle later. `pc_target` uses `epc` sampled in the RETURN cycle.
- Device edge to `hwint` bit set: 1 cycle.
- `rst` asserted mid-sequence (DRAIN/FLUSH/HANDLER/RETURN) returns to IDLE immediately with no redirect, flush or `exl_clr` pulse.
- All outputs are registered-state decodes; there is no combinational path from inputs to `stall`/`flush`/`pc_redirect`.

## Configuration
- `EXC_SEQ_IRQ_LEVEL_EN` defined:
  - `hwint` is the registered `dev_irq` (level, 1-cycle latency).
  - `irq_ack` is ignored.
  - No edge detection.
- Not defined: edge-triggered sticky pending as described in Operation.

## Test plan
- Device 2 rising edge with IE set -> `hwint`=6'b000100 the next cycle. With `int_req` driven high and `pipe_busy`=0 -> one-cycle `flush`/`pc_redirect` with `pc_target`=32'h0000_4180, `in_handler`=1, `int_count`=1.
- `int_req` with `pipe_busy` high for 3 cycles -> `stall`=1 for 3 cycles, redirect on the 4th. With `pipe_busy` stuck high and `DRAIN_MAX`=8 -> redirect forced after 8 DRAIN cycles.
- In HANDLER, `epc`=30'h0000_1003 and `eret` pulse -> next cycle `exl_clr`=1, `pc_target`=32'h0000_400C, then IDLE with `in_handler`=0.
- `dev_irq[0]` rising edge and `irq_ack[0]` in the same cycle -> `hwint[0]`=1. `irq_ack[0]` alone later -> `hwint[0]`=0.
- `int_req` and `eret` together in IDLE -> FLUSH path taken and `exl_clr` stays 0. `rst` pulsed while in DRAIN -> no redirect, state IDLE, `hwint`=0.
- With `EXC_SEQ_IRQ_LEVEL_EN` defined: `dev_irq`=6'b100001 held -> `hwint`=6'b100001 after 1 cycle. `irq_ack`=6'b111111 has no effect.
